// File: rtl/multi_timer_pkg.sv
// Shared register map and CONFIG field positions for the multi-channel timer.
package multi_timer_pkg;

  // Per-channel register offsets (low six address bits inside a channel window)
  localparam logic [5:0] OFF_CONFIG  = 6'h00;
  localparam logic [5:0] OFF_LO      = 6'h04;
  localparam logic [5:0] OFF_HI      = 6'h08;
  localparam logic [5:0] OFF_UPDATE  = 6'h0C;
  localparam logic [5:0] OFF_ALARMLO = 6'h10;
  localparam logic [5:0] OFF_ALARMHI = 6'h14;
  localparam logic [5:0] OFF_LOADLO  = 6'h18;
  localparam logic [5:0] OFF_LOADHI  = 6'h1C;
  localparam logic [5:0] OFF_LOAD    = 6'h20;

  // CONFIG bit indices
  localparam int CFG_ENABLE     = 31;
  localparam int CFG_INCREASE   = 30;
  localparam int CFG_AUTORELOAD = 29;
  localparam int CFG_DIV_MSB    = 28;
  localparam int CFG_DIV_LSB    = 13;
  localparam int CFG_ALARM_EN   = 10;

  // Channel windows and global registers (address bits [15:0])
  localparam logic [15:0] CH_BASE     = 16'hF000;
  localparam logic [15:0] CH_STRIDE   = 16'h0040;
  localparam logic [15:0] OFF_INT_RAW = 16'hF100;
  localparam logic [15:0] OFF_INT_ENA = 16'hF104;
  localparam logic [15:0] OFF_INT_CLR = 16'hF10C;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: prescaler, up/down counter, alarm compare, load and
// snapshot registers, plus the combinational readback of its own registers.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic [5:0]  reg_off,
  input  logic [31:0] wdata,
  output logic [31:0] rd_data,
  output logic        alarm_hit
);

  localparam int HW = CNT_W - 32;

  logic [31:0]      config_reg, config_next;
  logic [31:0]      alarm_lo_reg, load_lo_reg, snap_lo_reg;
  logic [HW-1:0]    alarm_hi_reg, load_hi_reg, snap_hi_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_step, alarm_val, load_val;
  logic [15:0]      presc_reg, presc_next, div_eff;
  logic             enable, tick, load_wr;

  always_comb begin
    enable    = config_reg[CFG_ENABLE];
    div_eff   = (config_reg[CFG_DIV_MSB:CFG_DIV_LSB] == 16'd0) ? 16'd1
                                                               : config_reg[CFG_DIV_MSB:CFG_DIV_LSB];
    // >= rather than == so a divider shrunk mid-count still ticks promptly
    tick      = enable && (presc_reg >= div_eff - 16'd1);
    alarm_val = {alarm_hi_reg, alarm_lo_reg};
    load_val  = {load_hi_reg, load_lo_reg};
    cnt_step  = config_reg[CFG_INCREASE] ? cnt_reg + CNT_W'(1) : cnt_reg - CNT_W'(1);
    load_wr   = wr && (reg_off == OFF_LOAD);
    alarm_hit = tick && config_reg[CFG_ALARM_EN] && (cnt_step == alarm_val) && !load_wr;

    presc_next = (!enable || tick) ? 16'd0 : presc_reg + 16'd1;

    cnt_next = cnt_reg;
    if (load_wr)
      cnt_next = load_val;
    else if (tick)
      cnt_next = (alarm_hit && config_reg[CFG_AUTORELOAD]) ? load_val : cnt_step;

    // A software CONFIG write wins over the alarm's self-clear of alarm_en
    config_next = config_reg;
    if (alarm_hit)
      config_next[CFG_ALARM_EN] = 1'b0;
    if (wr && (reg_off == OFF_CONFIG))
      config_next = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      config_reg   <= '0;
      presc_reg    <= '0;
      cnt_reg      <= '0;
      alarm_lo_reg <= '0;
      alarm_hi_reg <= '0;
      load_lo_reg  <= '0;
      load_hi_reg  <= '0;
      snap_lo_reg  <= '0;
      snap_hi_reg  <= '0;
    end else begin
      config_reg <= config_next;
      presc_reg  <= presc_next;
      cnt_reg    <= cnt_next;
      if (wr) begin
        case (reg_off)
          OFF_ALARMLO: alarm_lo_reg <= wdata;
          OFF_ALARMHI: alarm_hi_reg <= wdata[HW-1:0];
          OFF_LOADLO:  load_lo_reg  <= wdata;
          OFF_LOADHI:  load_hi_reg  <= wdata[HW-1:0];
          OFF_UPDATE: begin
            snap_lo_reg <= cnt_reg[31:0];
            snap_hi_reg <= cnt_reg[CNT_W-1:32];
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_off)
      OFF_CONFIG:  rd_data = config_reg;
      OFF_LO:      rd_data = snap_lo_reg;
      OFF_HI:      rd_data = 32'(snap_hi_reg);
      OFF_ALARMLO: rd_data = alarm_lo_reg;
      OFF_ALARMHI: rd_data = 32'(alarm_hi_reg);
      OFF_LOADLO:  rd_data = load_lo_reg;
      OFF_LOADHI:  rd_data = 32'(load_hi_reg);
      default:     rd_data = '0;
    endcase
  end

endmodule

// File: rtl/multi_timer.sv
// Memory-mapped multi-channel timer: address decode, registered readback and
// the shared interrupt raw/enable registers around NUM_CH timer channels.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int          NUM_CH  = 2,
  parameter int          CNT_W   = 64,
  parameter logic [15:0] BASE_HI = 16'h3FF5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       data_in,
  input  logic              wr_in,
  input  logic              rd_in,
  output logic              rd_valid_out,
  output logic [31:0]       data_out,
  output logic [NUM_CH-1:0] irq_out
);

  logic              hit, ch_region;
  logic [15:0]       off;
  logic [1:0]        ch_idx;
  logic [5:0]        reg_off;
  logic [31:0]       ch_rd_data [NUM_CH];
  logic [NUM_CH-1:0] alarm_hit, clr_mask, int_raw_reg, int_raw_next, int_ena_reg;
  logic [31:0]       rd_mux, data_out_reg;
  logic              rd_valid_reg;

  assign hit       = (addr_in[31:16] == BASE_HI);
  assign off       = addr_in[15:0];
  // Four 0x40-byte channel windows fill 0xF000-0xF0FF, so bits [7:6] pick the channel
  assign ch_region = hit && (off[15:8] == CH_BASE[15:8]);
  assign ch_idx    = off[7:6];
  assign reg_off   = off[5:0];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      timer_channel #(
        .CNT_W(CNT_W)
      ) u_ch (
        .clk      (clk),
        .rst      (rst),
        .wr       (wr_in && ch_region && (ch_idx == 2'(gi))),
        .reg_off  (reg_off),
        .wdata    (data_in),
        .rd_data  (ch_rd_data[gi]),
        .alarm_hit(alarm_hit[gi])
      );
    end
  endgenerate

  always_comb begin
    clr_mask = '0;
    if (wr_in && hit && (off == OFF_INT_CLR))
      clr_mask = data_in[NUM_CH-1:0];
    // A new alarm beats a same-cycle clear of the same bit
    int_raw_next = (int_raw_reg & ~clr_mask) | alarm_hit;

    rd_mux = '0;
    if (ch_region) begin
      for (int i = 0; i < NUM_CH; i++)
        if (ch_idx == 2'(i))
          rd_mux = ch_rd_data[i];
    end else if (hit) begin
      if (off == OFF_INT_RAW)
        rd_mux = 32'(int_raw_reg);
      else if (off == OFF_INT_ENA)
        rd_mux = 32'(int_ena_reg);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      int_raw_reg  <= '0;
      int_ena_reg  <= '0;
      data_out_reg <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      int_raw_reg <= int_raw_next;
      if (wr_in && hit && (off == OFF_INT_ENA))
        int_ena_reg <= data_in[NUM_CH-1:0];
      rd_valid_reg <= rd_in;
      data_out_reg <= rd_in ? rd_mux : 32'd0;
    end
  end

  assign rd_valid_out = rd_valid_reg;
  assign data_out     = data_out_reg;
  assign irq_out      = int_raw_reg & int_ena_reg;

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, meaning the number of independent timer channels (legal range 1-4).
REQ-002 The block SHALL have parameter CNT_W, default 64, meaning the counter width per channel (legal range 33-64).
REQ-003 The block SHALL have parameter BASE_HI, default 16'h3FF5, meaning the address bits [31:16] that select the block.
REQ-004 The block SHALL have these ports:
- clk, input, 1 bit: clock.
- rst, input, 1 bit: reset, synchronous, active-high.
- addr_in, input, 32 bits: MMIO address.
- data_in, input, 32 bits: write data.
- wr_in, input, 1 bit: write strobe.
- rd_in, input, 1 bit: read strobe.
- rd_valid_out, output, 1 bit: read data valid.
- data_out, output, 32 bits: read data.
- irq_out, output, NUM_CH bits: per-channel interrupt.

Function
REQ-005 An access SHALL be decoded only when addr_in[31:16]==BASE_HI; channel n register base SHALL be 16'hF000 + n*16'h40.
REQ-006 Per-channel offsets SHALL be:
- 0x00 CONFIG, RW.
- 0x04 LO and 0x08 HI, RO snapshot.
- 0x0C UPDATE, WO: snapshot counter into LO/HI.
- 0x10 ALARMLO and 0x14 ALARMHI, RW.
- 0x18 LOADLO and 0x1C LOADHI, RW.
- 0x20 LOAD, WO: counter <= {LOADHI,LOADLO}.
REQ-007 Global registers SHALL be:
- 0xF100 INT_RAW, RO.
- 0xF104 INT_ENA, RW.
- 0xF10C INT_CLR, WO, write-1-to-clear.
Bit n of each refers to channel n.
REQ-008 CONFIG fields SHALL be:
- [31] enable.
- [30] increase (1 up, 0 down).
- [29] autoreload.
- [28:13] divider.
- [10] alarm_en.
All other bits read back as written.
REQ-009 Reads SHALL have one-cycle latency: rd_valid_out is rd_in registered, and data_out is registered in the same cycle.
REQ-010 Reads of unmapped offsets, of channels >= NUM_CH, or of write-only registers SHALL return 0 with rd_valid_out still asserted.
REQ-011 HI reads SHALL return counter bits [CNT_W-1:32] zero-extended; ALARMHI and LOADHI storage SHALL be CNT_W-32 bits, with upper bits reading 0.
REQ-012 Each channel SHALL have a 16-bit prescaler that produces one tick every max(divider,1) cycles while enable=1; the prescaler SHALL hold at 0 while enable=0.
REQ-013 On a tick, the counter SHALL change by +1 or -1 modulo 2^CNT_W, so it wraps from all-ones to 0 counting up and from 0 to all-ones counting down.
REQ-014 On a tick with alarm_en=1 where the next counter value equals {ALARMHI,ALARMLO}, the block SHALL:
- set INT_RAW[n];
- clear CONFIG[10];
- load the counter with {LOADHI,LOADLO} if autoreload=1, otherwise with the next value.
REQ-015 A LOAD write SHALL take effect on the following edge and SHALL take priority over a same-cycle tick; a same-cycle alarm match SHALL be suppressed.
REQ-016 A CONFIG write coincident with a tick SHALL take effect on the next edge; that tick SHALL use the old CONFIG.
REQ-017 An INT_RAW set SHALL take priority over a same-cycle INT_CLR of the same bit.
REQ-018 irq_out[n] SHALL equal INT_RAW[n] & INT_ENA[n], driven from registers with no combinational path from inputs.
REQ-019 UPDATE SHALL capture the counter value present at the write edge.

Reset
REQ-020 On rst, the following SHALL be 0 on the next edge:
- all CONFIG, ALARM, LOAD, LO and HI registers;
- all counters and prescalers;
- INT_RAW and INT_ENA;
- data_out, rd_valid_out and irq_out.
REQ-021 A pending load or alarm SHALL be discarded when rst is asserted mid-operation.

Structure
REQ-022 Package multi_timer_pkg SHALL hold the register offset constants, CONFIG bit-index constants, the channel stride and the global register offsets.
REQ-023 Per-channel counter, prescaler, alarm and load logic SHALL live in sub-module timer_channel, instantiated NUM_CH times by a generate loop; decode, readback and interrupt registers SHALL live in multi_timer.

Verification
REQ-024 Scenario 1 SHALL check count-up: write CONFIG0=0xC0002000 (enable, up, divider=1); after 10 cycles write UPDATE0 and read LO0 -> 10±1; HI0 -> 0.
REQ-025 Scenario 2 SHALL check down-count wrap: LOAD0 with 0, then enable down with divider=1 -> the next tick reads LO0=0xFFFFFFFF and HI0=(2^(CNT_W-32))-1.
REQ-026 Scenario 3 SHALL check the alarm with autoreload: ALARM=100, LOAD=5, CONFIG=0xE0002400, INT_ENA=1 -> irq_out[0] rises one cycle after the counter reaches 100; the counter then reads 5; CONFIG0[10] reads 0.
REQ-027 Scenario 4 SHALL check prescaling: divider=4 -> the counter advances by 25 in 100 cycles; channel 1 stays at 0 while disabled.
REQ-028 Scenario 5 SHALL check simultaneous events: INT_CLR=1 in the same cycle as an alarm match -> INT_RAW[0] stays 1; a LOAD write on a tick edge -> the counter equals the LOAD value.
REQ-029 Scenario 6 SHALL check unmapped access and reset: a read of 0xF0FC -> rd_valid_out=1 and data_out=0; rst asserted mid-count -> all readback values 0 one cycle later.
